data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Two-port arbiter in front of a single word-wide data memory. Each port issues
// byte/half/word loads and stores. Loads and word stores complete in one memory
// cycle. Byte/half stores use a read-modify-write sequence that takes two
// memory cycles.
//
// Ports (i in {0,1}):
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   REQ_i            request valid; held stable until granted
//   ADDR_i           byte address, passed through unmodified
//   WDATA_i          store data; sub-word data sits in the low bits
//   WE_i             1 = store, 0 = load
//   SIZE_i           00 byte, 01 half, 1x word
//   UNS_i            1 = zero-extend loads, 0 = sign-extend loads
//   GNT_i            combinational grant; the request is taken at this edge
//   RVALID_i         one-cycle completion pulse
//   RDATA_i          registered, extended load data
//   MEM_A/WD/WE      word memory address, write data and write enable
//   MEM_RD           combinational read of bytes MEM_A..MEM_A+3, little-endian

module data_mem_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,

    input  logic             REQ_0,
    input  logic [WIDTH-1:0] ADDR_0,
    input  logic [WIDTH-1:0] WDATA_0,
    input  logic             WE_0,
    input  logic [1:0]       SIZE_0,
    input  logic             UNS_0,
    output logic             GNT_0,
    output logic             RVALID_0,
    output logic [WIDTH-1:0] RDATA_0,

    input  logic             REQ_1,
    input  logic [WIDTH-1:0] ADDR_1,
    input  logic [WIDTH-1:0] WDATA_1,
    input  logic             WE_1,
    input  logic [1:0]       SIZE_1,
    input  logic             UNS_1,
    output logic             GNT_1,
    output logic             RVALID_1,
    output logic [WIDTH-1:0] RDATA_1,

    output logic [WIDTH-1:0] MEM_A,
    output logic [WIDTH-1:0] MEM_WD,
    output logic             MEM_WE,
    input  logic [WIDTH-1:0] MEM_RD
);

    typedef enum logic [0:0] {StIdle, StRmw} state_e;

    state_e           state_q;
    logic             ptr_q;      // port favoured when both request
    logic             own_q;      // port owning the pending read-modify-write
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wd_q;       // merged word written in the RMW cycle
    logic             rvalid0_q, rvalid1_q;
    logic [WIDTH-1:0] rdata0_q, rdata1_q;

    logic             in_idle;
    logic             gnt0, gnt1, any_gnt, sel;
    logic [WIDTH-1:0] s_addr, s_wdata;
    logic             s_we, s_uns, s_word;
    logic [1:0]       s_size;
    logic [WIDTH-1:0] ld_data, merged;

    // Grants are masked during reset so a waiting request cannot reach memory.
    assign in_idle = RST_N && (state_q == StIdle);
    assign gnt0    = in_idle && REQ_0 && (!REQ_1 || !ptr_q);
    assign gnt1    = in_idle && REQ_1 && (!REQ_0 ||  ptr_q);
    assign any_gnt = gnt0 || gnt1;
    assign sel     = gnt1;

    assign GNT_0    = gnt0;
    assign GNT_1    = gnt1;
    assign RVALID_0 = rvalid0_q;
    assign RVALID_1 = rvalid1_q;
    assign RDATA_0  = rdata0_q;
    assign RDATA_1  = rdata1_q;

    // Selected request fields
    assign s_addr  = sel ? ADDR_1  : ADDR_0;
    assign s_wdata = sel ? WDATA_1 : WDATA_0;
    assign s_we    = sel ? WE_1    : WE_0;
    assign s_size  = sel ? SIZE_1  : SIZE_0;
    assign s_uns   = sel ? UNS_1   : UNS_0;
    assign s_word  = s_size[1];   // 10 and 11 are both word

    // Load extraction and extension
    always_comb begin
        ld_data = MEM_RD;
        if (!s_size[1]) begin
            if (s_size[0]) begin
                ld_data = s_uns ? {{(WIDTH-16){1'b0}}, MEM_RD[15:0]}
                                : {{(WIDTH-16){MEM_RD[15]}}, MEM_RD[15:0]};
            end else begin
                ld_data = s_uns ? {{(WIDTH-8){1'b0}}, MEM_RD[7:0]}
                                : {{(WIDTH-8){MEM_RD[7]}}, MEM_RD[7:0]};
            end
        end
    end

    // Sub-word store data merged into the word currently read from memory
    always_comb begin
        if (s_size[0]) begin
            merged = {MEM_RD[WIDTH-1:16], s_wdata[15:0]};
        end else begin
            merged = {MEM_RD[WIDTH-1:8], s_wdata[7:0]};
        end
    end

    // Memory port drive
    always_comb begin
        MEM_A  = '0;
        MEM_WD = '0;
        MEM_WE = 1'b0;
        if (RST_N && (state_q == StRmw)) begin
            MEM_A  = addr_q;
            MEM_WD = wd_q;
            MEM_WE = 1'b1;
        end else if (any_gnt) begin
            MEM_A = s_addr;
            if (s_we && s_word) begin
                MEM_WD = s_wdata;
                MEM_WE = 1'b1;
            end
        end
    end

    // State machine with registered completion outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            own_q     <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_gnt) begin
                        ptr_q <= ~sel;
                        if (s_we && !s_word) begin
                            state_q <= StRmw;
                            own_q   <= sel;
                            addr_q  <= s_addr;
                            wd_q    <= merged;
                        end else begin
                            if (sel) begin
                                rvalid1_q <= 1'b1;
                                if (!s_we) rdata1_q <= ld_data;
                            end else begin
                                rvalid0_q <= 1'b1;
                                if (!s_we) rdata0_q <= ld_data;
                            end
                        end
                    end
                end
                StRmw: begin
                    state_q <= StIdle;
                    if (own_q) rvalid1_q <= 1'b1;
                    else       rvalid0_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        we    [2];
    logic [1:0]  size  [2];
    logic        uns   [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_arbiter #(.WIDTH(32)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .REQ_0   (req[0]),
        .ADDR_0  (addr[0]),
        .WDATA_0 (wdata[0]),
        .WE_0    (we[0]),
        .SIZE_0  (size[0]),
        .UNS_0   (uns[0]),
        .GNT_0   (gnt[0]),
        .RVALID_0(rvalid[0]),
        .RDATA_0 (rdata[0]),
        .REQ_1   (req[1]),
        .ADDR_1  (addr[1]),
        .WDATA_1 (wdata[1]),
        .WE_1    (we[1]),
        .SIZE_1  (size[1]),
        .UNS_1   (uns[1]),
        .GNT_1   (gnt[1]),
        .RVALID_1(rvalid[1]),
        .RDATA_1 (rdata[1]),
        .MEM_A   (mem_a),
        .MEM_WD  (mem_wd),
        .MEM_WE  (mem_we),
        .MEM_RD  (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            req[p]   = 1'b0;
            addr[p]  = '0;
            wdata[p] = '0;
            we[p]    = 1'b0;
            size[p]  = 2'b10;
            uns[p]   = 1'b0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        size[p]  = sz;
        uns[p]   = u;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single port-0 load from an idle arbiter: grant now, data one cycle later
    task automatic load0(input string tag, input logic [1:0] sz, input logic u,
                         input logic [31:0] rd, input logic [31:0] exp);
        set_req(0, 1'b0, sz, u, 32'h0001_0000, 32'h0);
        mem_rd = rd;
        settle();
        check({tag, "_gnt"}, {31'b0, gnt[0]}, 32'd1);
        next_cycle();
        req[0] = 1'b0;
        settle();
        check({tag, "_rvalid"}, {31'b0, rvalid[0]}, 32'd1);
        check({tag, "_rdata"}, rdata[0], exp);
        next_cycle();
    endtask

    logic exp_port;

    initial begin
        rst_n  = 1'b0;
        mem_rd = '0;
        clear_inputs();
        // Pending word store during reset must not reach memory
        set_req(0, 1'b1, 2'b10, 1'b0, 32'h44, 32'h1234_5678);
        settle();
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_rvalid0", {31'b0, rvalid[0]}, 32'd0);
        check("rst_rvalid1", {31'b0, rvalid[1]}, 32'd0);
        check("rst_rdata0", rdata[0], 32'h0);
        check("rst_rdata1", rdata[1], 32'h0);
        do_reset();

        // Byte load, signed: grant in cycle 0, address and no write
        set_req(0, 1'b0, 2'b00, 1'b0, 32'h0001_0000, 32'h0);
        mem_rd = 32'h8899_AABB;
        settle();
        check("bl_gnt0", {31'b0, gnt[0]}, 32'd1);
        check("bl_gnt1", {31'b0, gnt[1]}, 32'd0);
        check("bl_mem_a", mem_a, 32'h0001_0000);
        check("bl_mem_we", {31'b0, mem_we}, 32'd0);
        next_cycle();
        req[0] = 1'b0;
        settle();
        check("bl_rvalid0", {31'b0, rvalid[0]}, 32'd1);
        check("bl_rdata0", rdata[0], 32'hFFFF_FFBB);
        next_cycle();

        load0("hu", 2'b01, 1'b1, 32'h8899_AABB, 32'h0000_AABB);
        load0("hs", 2'b01, 1'b0, 32'h8899_AABB, 32'hFFFF_AABB);
        load0("bu", 2'b00, 1'b1, 32'h8899_AABB, 32'h0000_00BB);
        load0("bs_pos", 2'b00, 1'b0, 32'h8899_AA7F, 32'h0000_007F);
        load0("w11", 2'b11, 1'b0, 32'h8899_AABB, 32'h8899_AABB);

        // Both ports requesting word loads every cycle: 0,1,0,1 after reset
        do_reset();
        mem_rd = 32'hCAFE_F00D;
        set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            settle();
            check($sformatf("arb%0d_gnt0", k), {31'b0, gnt[0]}, {31'b0, ~exp_port});
            check($sformatf("arb%0d_gnt1", k), {31'b0, gnt[1]}, {31'b0, exp_port});
            if (k > 0) begin
                // completion of the previous grant alongside the new grant
                check($sformatf("arb%0d_rvalid_prev", k),
                      {31'b0, rvalid[exp_port ? 0 : 1]}, 32'd1);
            end
            next_cycle();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        settle();
        check("arb_last_rvalid1", {31'b0, rvalid[1]}, 32'd1);
        check("arb_last_rdata1", rdata[1], 32'hCAFE_F00D);
        next_cycle();

        // Port 1 byte store via read-modify-write; port 0 waits during RMW
        set_req(1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_005A);
        mem_rd = 32'h1122_3344;
        settle();
        check("bs_gnt1", {31'b0, gnt[1]}, 32'd1);
        check("bs_c0_mem_we", {31'b0, mem_we}, 32'd0);
        check("bs_c0_mem_a", mem_a, 32'h20);
        next_cycle();
        req[1] = 1'b0;
        set_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        mem_rd = 32'h0;   // merged word must come from the latched read
        settle();
        check("bs_c1_gnt0", {31'b0, gnt[0]}, 32'd0);
        check("bs_c1_mem_we", {31'b0, mem_we}, 32'd1);
        check("bs_c1_mem_wd", mem_wd, 32'h1122_335A);
        check("bs_c1_mem_a", mem_a, 32'h20);
        check("bs_c1_rvalid1", {31'b0, rvalid[1]}, 32'd0);
        next_cycle();
        settle();
        check("bs_c2_rvalid1", {31'b0, rvalid[1]}, 32'd1);
        check("bs_c2_gnt0", {31'b0, gnt[0]}, 32'd1);
        check("bs_c2_mem_a", mem_a, 32'h40);
        check("bs_rdata1_kept", rdata[1], 32'hCAFE_F00D);
        next_cycle();
        req[0] = 1'b0;
        settle();
        check("bs_c3_rvalid0", {31'b0, rvalid[0]}, 32'd1);
        check("bs_c3_rdata0", rdata[0], 32'h0);
        next_cycle();

        // Port 0 half store
        set_req(0, 1'b1, 2'b01, 1'b0, 32'h60, 32'h1234_ABCD);
        mem_rd = 32'h1122_3344;
        settle();
        check("hs_gnt0", {31'b0, gnt[0]}, 32'd1);
        next_cycle();
        req[0] = 1'b0;
        settle();
        check("hs_mem_we", {31'b0, mem_we}, 32'd1);
        check("hs_mem_wd", mem_wd, 32'h1122_ABCD);
        next_cycle();
        settle();
        check("hs_rvalid0", {31'b0, rvalid[0]}, 32'd1);
        next_cycle();

        // Port 0 word store (SIZE 11): single cycle write
        set_req(0, 1'b1, 2'b11, 1'b0, 32'h80, 32'hDEAD_BEEF);
        settle();
        check("ws_gnt0", {31'b0, gnt[0]}, 32'd1);
        check("ws_mem_we", {31'b0, mem_we}, 32'd1);
        check("ws_mem_wd", mem_wd, 32'hDEAD_BEEF);
        check("ws_mem_a", mem_a, 32'h80);
        next_cycle();
        req[0] = 1'b0;
        settle();
        check("ws_rvalid0", {31'b0, rvalid[0]}, 32'd1);
        check("ws_rdata0_kept", rdata[0], 32'h0);
        check("idle_mem_we", {31'b0, mem_we}, 32'd0);
        check("idle_mem_a", mem_a, 32'h0);
        check("idle_mem_wd", mem_wd, 32'h0);
        next_cycle();

        // Reset asserted in the RMW cycle aborts the write
        set_req(1, 1'b1, 2'b00, 1'b0, 32'h90, 32'h0000_0077);
        settle();
        check("ra_gnt1", {31'b0, gnt[1]}, 32'd1);
        next_cycle();
        req[1] = 1'b0;
        settle();
        check("ra_rmw_we", {31'b0, mem_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ra_abort_we", {31'b0, mem_we}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b0, 2'b00, 1'b1, 32'hA0, 32'h0);
        mem_rd = 32'h0000_00F0;
        settle();
        check("ra_no_rvalid1", {31'b0, rvalid[1]}, 32'd0);
        check("ra_gnt0_first", {31'b0, gnt[0]}, 32'd1);
        next_cycle();
        req[0] = 1'b0;
        settle();
        check("ra_rvalid0", {31'b0, rvalid[0]}, 32'd1);
        check("ra_rdata0", rdata[0], 32'h0000_00F0);
        check("ra_no_rvalid1_late", {31'b0, rvalid[1]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
